// File: rtl/ctrl_pipe_if.sv
// Control-bundle interface between the decode stage and the control pipeline.
// The master side drives decode bundles and hazard inputs; the slave side returns per-stage controls.
interface ctrl_pipe_if;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [3:0]  ex_in;
  logic        id_valid;
  logic        stall;
  logic        ex_zero;

  logic        reg_dst;
  logic [1:0]  alu_op;
  logic        alu_src;
  logic        ex_valid;
  logic        branch;
  logic        mem_read;
  logic        mem_write;
  logic        pcsrc;
  logic        reg_write;
  logic        mem_to_reg;
  logic        wb_valid;
  logic [31:0] retired;

  modport master (
    output wb_in, m_in, ex_in, id_valid, stall, ex_zero,
    input  reg_dst, alu_op, alu_src, ex_valid,
    input  branch, mem_read, mem_write, pcsrc,
    input  reg_write, mem_to_reg, wb_valid, retired
  );

  modport slave (
    input  wb_in, m_in, ex_in, id_valid, stall, ex_zero,
    output reg_dst, alu_op, alu_src, ex_valid,
    output branch, mem_read, mem_write, pcsrc,
    output reg_write, mem_to_reg, wb_valid, retired
  );
endinterface

// File: rtl/ctrl_pipe.sv
// Carries decode control bundles through ID/EX, EX/MEM and MEM/WB, inserting
// load-use bubbles, squashing on a taken branch and counting retired instructions.
module ctrl_pipe (
  input  logic        clk,
  input  logic        rst,
  ctrl_pipe_if.slave  bus
);
  logic [1:0]  idex_wb_reg;
  logic [2:0]  idex_m_reg;
  logic [3:0]  idex_ex_reg;
  logic        idex_valid_reg;

  logic [1:0]  exmem_wb_reg;
  logic [2:0]  exmem_m_reg;
  logic        exmem_zero_reg;
  logic        exmem_valid_reg;

  logic [1:0]  memwb_wb_reg;
  logic        memwb_valid_reg;

  logic [31:0] retired_reg;
  logic        pcsrc;

  // A bubble carries branch=0, so pcsrc can only fire for a real branch.
  assign pcsrc = exmem_m_reg[2] & exmem_zero_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_wb_reg     <= '0;
      idex_m_reg      <= '0;
      idex_ex_reg     <= '0;
      idex_valid_reg  <= 1'b0;
      exmem_wb_reg    <= '0;
      exmem_m_reg     <= '0;
      exmem_zero_reg  <= 1'b0;
      exmem_valid_reg <= 1'b0;
      memwb_wb_reg    <= '0;
      memwb_valid_reg <= 1'b0;
      retired_reg     <= '0;
    end else begin
      // Squash and load-use stall both just replace the incoming bundle with a bubble.
      if (pcsrc || bus.stall) begin
        idex_wb_reg    <= '0;
        idex_m_reg     <= '0;
        idex_ex_reg    <= '0;
        idex_valid_reg <= 1'b0;
      end else begin
        idex_wb_reg    <= bus.wb_in;
        idex_m_reg     <= bus.m_in;
        idex_ex_reg    <= bus.ex_in;
        idex_valid_reg <= bus.id_valid;
      end

      if (pcsrc) begin
        exmem_wb_reg    <= '0;
        exmem_m_reg     <= '0;
        exmem_zero_reg  <= 1'b0;
        exmem_valid_reg <= 1'b0;
      end else begin
        exmem_wb_reg    <= idex_wb_reg;
        exmem_m_reg     <= idex_m_reg;
        exmem_zero_reg  <= bus.ex_zero;
        exmem_valid_reg <= idex_valid_reg;
      end

      memwb_wb_reg    <= exmem_wb_reg;
      memwb_valid_reg <= exmem_valid_reg;

      if (memwb_valid_reg) begin
        retired_reg <= retired_reg + 32'd1;
      end
    end
  end

  assign bus.reg_dst    = idex_ex_reg[3];
  assign bus.alu_op     = idex_ex_reg[2:1];
  assign bus.alu_src    = idex_ex_reg[0];
  assign bus.ex_valid   = idex_valid_reg;
  assign bus.branch     = exmem_m_reg[2];
  assign bus.mem_read   = exmem_m_reg[1];
  assign bus.mem_write  = exmem_m_reg[0];
  assign bus.pcsrc      = pcsrc;
  assign bus.reg_write  = memwb_wb_reg[1];
  assign bus.mem_to_reg = memwb_wb_reg[0];
  assign bus.wb_valid   = memwb_valid_reg;
  assign bus.retired    = retired_reg;
endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed vector table, hand-written hazard
// sequences and a randomized run against a slot-list model of the pipeline.
module tb_ctrl_pipe;
  logic clk;
  logic rst;
  ctrl_pipe_if bus ();

  ctrl_pipe dut (.clk(clk), .rst(rst), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
    logic       zero;
    logic       valid;
  } slot_t;

  // Model: slot 0 = EX, 1 = MEM, 2 = WB.
  slot_t       pipe [3];
  int unsigned m_ret;
  int          checks;
  int          failures;

  typedef struct {
    logic        r;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic        v;
    logic        s;
    logic        z;
    logic [4:0]  exp_ex;   // {reg_dst, alu_op, alu_src, ex_valid}
    logic [3:0]  exp_mem;  // {branch, mem_read, mem_write, pcsrc}
    logic [2:0]  exp_wb;   // {reg_write, mem_to_reg, wb_valid}
    logic [31:0] exp_ret;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ex_bus();
    return {bus.reg_dst, bus.alu_op, bus.alu_src, bus.ex_valid};
  endfunction
  function automatic logic [3:0] mem_bus();
    return {bus.branch, bus.mem_read, bus.mem_write, bus.pcsrc};
  endfunction
  function automatic logic [2:0] wb_bus();
    return {bus.reg_write, bus.mem_to_reg, bus.wb_valid};
  endfunction

  // Apply one cycle of inputs, advance the model and the DUT by one edge.
  task automatic step(input logic r, input logic [1:0] w, input logic [2:0] m,
                      input logic [3:0] e, input logic v, input logic s, input logic z);
    slot_t       nxt [3];
    int unsigned ret_n;
    logic        taken;
    rst = r; bus.wb_in = w; bus.m_in = m; bus.ex_in = e;
    bus.id_valid = v; bus.stall = s; bus.ex_zero = z;
    taken = pipe[1].m[2] & pipe[1].zero;
    if (r) begin
      nxt[0] = '0; nxt[1] = '0; nxt[2] = '0;
      ret_n = 0;
    end else begin
      ret_n = m_ret + (pipe[2].valid ? 1 : 0);
      nxt[2] = '0;
      nxt[2].wb = pipe[1].wb;
      nxt[2].valid = pipe[1].valid;
      if (taken) nxt[1] = '0;
      else begin
        nxt[1] = pipe[0];
        nxt[1].zero = z;
      end
      if (taken || s) nxt[0] = '0;
      else nxt[0] = '{wb: w, m: m, ex: e, zero: 1'b0, valid: v};
    end
    @(posedge clk);
    #1;
    pipe[0] = nxt[0]; pipe[1] = nxt[1]; pipe[2] = nxt[2];
    m_ret = ret_n;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ex"},  {27'd0, ex_bus()},  {27'd0, pipe[0].ex, pipe[0].valid});
    chk({tag, "_mem"}, {28'd0, mem_bus()}, {28'd0, pipe[1].m, pipe[1].m[2] & pipe[1].zero});
    chk({tag, "_wb"},  {29'd0, wb_bus()},  {29'd0, pipe[2].wb, pipe[2].valid});
    chk({tag, "_ret"}, bus.retired, m_ret);
  endtask

  function automatic vec_t mk(logic r, logic [1:0] w, logic [2:0] m, logic [3:0] e,
                              logic v, logic [4:0] xe, logic [3:0] xm, logic [2:0] xw,
                              logic [31:0] xr);
    vec_t t;
    t = '{r: r, wb: w, m: m, ex: e, v: v, s: 1'b0, z: 1'b0,
          exp_ex: xe, exp_mem: xm, exp_wb: xw, exp_ret: xr};
    return t;
  endfunction

  initial begin
    int base;
    int pc_cnt;
    int rw_seen;
    checks = 0; failures = 0; m_ret = 0;
    pipe[0] = '0; pipe[1] = '0; pipe[2] = '0;
    rst = 1'b1; bus.wb_in = '0; bus.m_in = '0; bus.ex_in = '0;
    bus.id_valid = 1'b0; bus.stall = 1'b0; bus.ex_zero = 1'b0;

    // Reset, idle, then R-type / lw / sw / beq with ex_zero=0.
    tbl[0]  = mk(1, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 0);
    tbl[1]  = mk(1, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 0);
    tbl[2]  = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 0);
    tbl[3]  = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 0);
    tbl[4]  = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 0);
    tbl[5]  = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 0);
    tbl[6]  = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 0);
    tbl[7]  = mk(0, 2'b10, 3'b000, 4'b1100, 1, 5'b11001, 4'b0000, 3'b000, 0);
    tbl[8]  = mk(0, 2'b11, 3'b010, 4'b0001, 1, 5'b00011, 4'b0000, 3'b000, 0);
    tbl[9]  = mk(0, 2'b00, 3'b001, 4'b0001, 1, 5'b00011, 4'b0100, 3'b101, 0);
    tbl[10] = mk(0, 2'b00, 3'b100, 4'b0010, 1, 5'b00101, 4'b0010, 3'b111, 1);
    tbl[11] = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b1000, 3'b001, 2);
    tbl[12] = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b001, 3);
    tbl[13] = mk(0, 2'b00, 3'b000, 4'b0000, 0, 5'b00000, 4'b0000, 3'b000, 4);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].wb, tbl[i].m, tbl[i].ex, tbl[i].v, tbl[i].s, tbl[i].z);
      chk($sformatf("tbl%0d_ex", i),  {27'd0, ex_bus()},  {27'd0, tbl[i].exp_ex});
      chk($sformatf("tbl%0d_mem", i), {28'd0, mem_bus()}, {28'd0, tbl[i].exp_mem});
      chk($sformatf("tbl%0d_wb", i),  {29'd0, wb_bus()},  {29'd0, tbl[i].exp_wb});
      chk($sformatf("tbl%0d_ret", i), bus.retired, tbl[i].exp_ret);
      $display("vec %0d: ex=%b mem=%b wb=%b retired=%0d", i, ex_bus(), mem_bus(), wb_bus(), bus.retired);
    end

    // Taken branch: beq, then R with ex_zero=1 while beq is in EX, then R.
    base = int'(m_ret); pc_cnt = 0; rw_seen = 0;
    step(0, 2'b00, 3'b100, 4'b0010, 1, 0, 0);
    check_model("br0");
    step(0, 2'b10, 3'b000, 4'b1100, 1, 0, 1);
    check_model("br1");
    if (bus.pcsrc) pc_cnt++;
    step(0, 2'b10, 3'b000, 4'b1100, 1, 0, 0);
    check_model("br2");
    if (bus.pcsrc) pc_cnt++;
    for (int k = 0; k < 4; k++) begin
      idle();
      check_model("br_drain");
      if (bus.pcsrc) pc_cnt++;
      if (bus.reg_write) rw_seen++;
    end
    chk("br_pcsrc_cycles", pc_cnt, 1);
    chk("br_squashed_regwrite", rw_seen, 0);
    chk("br_retired_delta", bus.retired, base + 1);
    $display("taken branch: pcsrc cycles=%0d retired=%0d", pc_cnt, bus.retired);

    // Load-use stall: lw, R held under stall, R released.
    base = int'(m_ret);
    step(0, 2'b11, 3'b010, 4'b0001, 1, 0, 0);
    check_model("st0");
    step(0, 2'b10, 3'b000, 4'b1100, 1, 1, 0);
    check_model("st1");
    chk("stall_bubble_ex", {27'd0, ex_bus()}, 32'd0);
    step(0, 2'b10, 3'b000, 4'b1100, 1, 0, 0);
    check_model("st2");
    chk("late_rtype_ex", {27'd0, ex_bus()}, 32'b11001);
    for (int k = 0; k < 4; k++) begin
      idle();
      check_model("st_drain");
    end
    chk("stall_retired_delta", bus.retired, base + 2);
    $display("load-use stall: retired=%0d", bus.retired);

    // Reset with three instructions in flight.
    step(0, 2'b10, 3'b000, 4'b1100, 1, 0, 0);
    step(0, 2'b11, 3'b010, 4'b0001, 1, 0, 0);
    step(0, 2'b00, 3'b001, 4'b0001, 1, 0, 0);
    step(1, 2'b00, 3'b000, 4'b0000, 0, 0, 0);
    chk("midrst_outputs", {20'd0, ex_bus(), mem_bus(), wb_bus()}, 32'd0);
    chk("midrst_retired", bus.retired, 32'd0);
    for (int k = 0; k < 4; k++) idle();
    chk("midrst_not_counted", bus.retired, 32'd0);
    $display("mid reset: retired=%0d", bus.retired);

    // Counter wrap from FFFFFFFE.
    force dut.retired_reg = 32'hFFFF_FFFE;
    idle();
    release dut.retired_reg;
    m_ret = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) step(0, 2'b10, 3'b000, 4'b1100, 1, 0, 0);
    idle();
    chk("wrap_ffffffff", bus.retired, 32'hFFFF_FFFF);
    idle();
    chk("wrap_00000000", bus.retired, 32'h0000_0000);
    idle();
    chk("wrap_00000001", bus.retired, 32'h0000_0001);
    check_model("wrap");
    $display("counter wrap: retired=%h", bus.retired);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [1:0] w;
      logic [2:0] m;
      logic [3:0] e;
      w = 2'($urandom); m = 3'($urandom); e = 4'($urandom);
      step(($urandom_range(0, 49) == 0), w, m, e, 1'($urandom),
           ($urandom_range(0, 3) == 0), 1'($urandom));
      check_model("rnd");
      $display("rnd %0d: ex=%b mem=%b wb=%b retired=%0d", k, ex_bus(), mem_bus(), wb_bus(), bus.retired);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
